// File: rtl/dpr_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// dpr_fifo_ctrl
// Synchronous FIFO controller in front of a 4096 x 8 true dual-port RAM.
// RAM port 0 is the write port, port 1 is the read port. The read side is
// first-word-fall-through: m_data is the RAM's registered port-1 read data,
// addressed one cycle ahead with rd_ptr_nxt.
//
// Optional feature macro: DPR_FIFO_HWM_EN
//   When defined, adds output hwm, the highest occupancy seen since rst.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module dpr_fifo_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   // upstream (write) side
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   // downstream (read) side
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   // occupancy
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   // RAM port 0 (write)
   output logic              ram_wr_en_0,
   output logic [ADDR_W-1:0] ram_addr_0,
   output logic [DATA_W-1:0] ram_in_0,
   // RAM port 1 (read)
   output logic              ram_wr_en_1,
   output logic [ADDR_W-1:0] ram_addr_1,
   input  logic [DATA_W-1:0] ram_out_1
`ifdef DPR_FIFO_HWM_EN
   ,
   output logic [ADDR_W:0]   hwm
`endif
);

   // Occupancy value that means "every RAM word holds unread data".
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

   // Pointers carry one extra wrap bit above the RAM address.
   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] rd_ptr;
   logic [ADDR_W:0] rd_ptr_nxt;
   logic [ADDR_W:0] count_nxt;
   logic            push;
   logic            pop;

   // Status decoded from the registered count only, so s_ready never depends
   // combinationally on the downstream handshake.
   assign full    = (count == DEPTH);
   assign empty   = (count == '0);
   assign s_ready = ~full;

   assign push = s_valid & s_ready;
   assign pop  = m_valid & m_ready;

   // The read address runs one word ahead on a pop so the RAM's registered
   // output already holds the next word after the same edge.
   assign rd_ptr_nxt = pop ? (rd_ptr + ONE) : rd_ptr;

   // RAM port wiring. Port 1 never writes.
   assign ram_wr_en_0 = push;
   assign ram_addr_0  = wr_ptr[ADDR_W-1:0];
   assign ram_in_0    = s_data;
   assign ram_wr_en_1 = 1'b0;
   assign ram_addr_1  = rd_ptr_nxt[ADDR_W-1:0];
   assign m_data      = ram_out_1;

   // Next occupancy from this cycle's push and pop.
   always_comb begin
      // NOTE: assigning a default first keeps every path driven, so no latch
      // is inferred when neither branch below matches.
      count_nxt = count;
      unique case ({push, pop})
         2'b10:   count_nxt = count + ONE;
         2'b01:   count_nxt = count - ONE;
         default: count_nxt = count;
      endcase
   end

   // Pointer, occupancy and output-valid registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         m_valid <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ONE;
         end
         rd_ptr  <= rd_ptr_nxt;
         count   <= count_nxt;
         // The RAM read issued at this edge returns pre-edge contents, so only
         // words committed before this edge (below the old wr_ptr) are readable.
         m_valid <= (wr_ptr != rd_ptr_nxt);
      end
   end

   // NOTE: the RAM array itself is never cleared; after rst any stale
   // ram_out_1 is masked because m_valid restarts at 0.

`ifdef DPR_FIFO_HWM_EN
   // High-water mark of occupancy since the last rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         hwm <= '0;
      end else if (count_nxt > hwm) begin
         hwm <= count_nxt;
      end
   end
`endif

   // Handshake invariants of the streaming interfaces.
   a_count_range : assert property (@(posedge clk) disable iff (rst)
      count <= DEPTH);
   a_no_push_full : assert property (@(posedge clk) disable iff (rst)
      full |-> !ram_wr_en_0);
   a_valid_held : assert property (@(posedge clk) disable iff (rst)
      (m_valid && !m_ready) |=> m_valid);
   a_data_held : assert property (@(posedge clk) disable iff (rst)
      (m_valid && !m_ready) |=> $stable(m_data));

endmodule

// File: tb/tb_dpr_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dpr_fifo_ctrl
// Self-checking bench for dpr_fifo_ctrl. Contains a behavioural model of the
// 4096 x 8 RAM (read-first registered port 1) and a queue-based reference of
// the FIFO, compared against the DUT every cycle, plus directed scenarios with
// hand-computed expectations and a randomized phase.
// Build with DPR_FIFO_HWM_EN defined to also exercise the hwm output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dpr_fifo_ctrl;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 12;
   localparam int DEPTH  = 4096;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [DATA_W-1:0] s_data = '0;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic [DATA_W-1:0] m_data;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              empty;
   logic              ram_wr_en_0;
   logic [ADDR_W-1:0] ram_addr_0;
   logic [DATA_W-1:0] ram_in_0;
   logic              ram_wr_en_1;
   logic [ADDR_W-1:0] ram_addr_1;
   logic [DATA_W-1:0] ram_out_1 = '0;
`ifdef DPR_FIFO_HWM_EN
   logic [ADDR_W:0]   hwm;
`endif

   dpr_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .ram_wr_en_0 (ram_wr_en_0),
      .ram_addr_0  (ram_addr_0),
      .ram_in_0    (ram_in_0),
      .ram_wr_en_1 (ram_wr_en_1),
      .ram_addr_1  (ram_addr_1),
      .ram_out_1   (ram_out_1)
`ifdef DPR_FIFO_HWM_EN
      ,
      .hwm         (hwm)
`endif
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- RAM model
   logic [DATA_W-1:0] mem [DEPTH];

   // Registered read on port 1 returns pre-edge contents (read-first).
   always @(posedge clk) begin
      if (ram_wr_en_0) mem[ram_addr_0] <= ram_in_0;
      ram_out_1 <= mem[ram_addr_1];
   end

   // ---------------------------------------------------------- check plumbing
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------- reference model
   // Each stored word remembers the clock edge that wrote it. A word becomes
   // visible on m_data after the first edge strictly later than its write.
   typedef struct {
      logic [DATA_W-1:0] data;
      int                edge_no;
   } entry_t;

   entry_t q[$];
   int     edge_no = 0;
   bit     mv_mdl  = 1'b0;
   int     n_push  = 0;
   int     n_pop   = 0;
   int     hwm_mdl = 0;
   bit     mdl_ok  = 1'b0;
   bit     m_push;
   bit     m_pop;

   always @(posedge clk) begin
      edge_no++;
      if (rst) begin
         q.delete();
         mv_mdl  = 1'b0;
         n_push  = 0;
         n_pop   = 0;
         hwm_mdl = 0;
         mdl_ok  = 1'b1;
      end else begin
         m_push = s_valid && (q.size() < DEPTH);
         m_pop  = mv_mdl && m_ready;
         if (m_pop) begin
            void'(q.pop_front());
            n_pop++;
         end
         if (m_push) begin
            q.push_back('{s_data, edge_no});
            n_push++;
         end
         mv_mdl = (q.size() > 0) && (q[0].edge_no < edge_no);
         if (q.size() > hwm_mdl) hwm_mdl = q.size();
      end
   end

   // Compare every output against the model, away from the active edge.
   always @(negedge clk) begin
      if (mdl_ok) begin
         check("count",   count,   q.size());
         check("full",    full,    q.size() == DEPTH);
         check("empty",   empty,   q.size() == 0);
         check("s_ready", s_ready, q.size() != DEPTH);
         check("m_valid", m_valid, mv_mdl);
         if (mv_mdl) check("m_data", m_data, q[0].data);
         check("ram_wr_en_0", ram_wr_en_0, s_valid && (q.size() < DEPTH));
         check("ram_addr_0",  ram_addr_0,  n_push % DEPTH);
         check("ram_in_0",    ram_in_0,    s_data);
         check("ram_wr_en_1", ram_wr_en_1, 0);
         check("ram_addr_1",  ram_addr_1,  (n_pop + ((mv_mdl && m_ready) ? 1 : 0)) % DEPTH);
`ifdef DPR_FIFO_HWM_EN
         check("hwm", hwm, hwm_mdl);
`endif
      end
   end

   // --------------------------------------------------------- stimulus helpers
   task automatic drive(input bit sv, input logic [DATA_W-1:0] d, input bit mr);
      s_valid = sv;
      s_data  = d;
      m_ready = mr;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drain();
      drive(1'b0, '0, 1'b1);
      for (int c = 0; c < 5000 && (count != 0 || m_valid); c++) tick();
      drive(1'b0, '0, 1'b0);
      check("drain_empty", empty, 1);
   endtask

   // Watchdog: every loop is bounded, this only catches a stuck simulator.
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // -------------------------------------------------------------- scenarios
   initial begin
      logic [DATA_W-1:0] got[$];
      int gaps, errs, max_cnt, idx, stream_n;
      bit seen, acc;

      // Reset state.
      rst = 1'b1;
      drive(1'b0, '0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      check("rst_count",   count,   0);
      check("rst_empty",   empty,   1);
      check("rst_full",    full,    0);
      check("rst_s_ready", s_ready, 1);
      check("rst_m_valid", m_valid, 0);

      // Single word: visible one edge after the push edge, then held.
      drive(1'b1, 8'hA5, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0);
      check("single_count",   count,   1);
      check("single_mv_early", m_valid, 0);
      tick();
      check("single_m_valid", m_valid, 1);
      check("single_m_data",  m_data,  8'hA5);
      for (int i = 0; i < 10; i++) tick();
      check("single_hold_valid", m_valid, 1);
      check("single_hold_data",  m_data,  8'hA5);
      drive(1'b0, '0, 1'b1);
      tick();
      drive(1'b0, '0, 1'b0);
      check("single_popped_valid", m_valid, 0);
      check("single_popped_count", count,   0);

      // Streaming 0x00..0xFF with m_ready high: in order, no gaps, count <= 2.
      got.delete();
      gaps = 0; max_cnt = 0; seen = 1'b0;
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, 8'(i), 1'b1);
         if (m_valid) begin got.push_back(m_data); seen = 1'b1; end
         else if (seen) gaps++;
         tick();
         if (int'(count) > max_cnt) max_cnt = int'(count);
      end
      drive(1'b0, '0, 1'b1);
      for (int c = 0; c < 10 && got.size() < 256; c++) begin
         if (m_valid) got.push_back(m_data);
         else if (seen) gaps++;
         tick();
      end
      errs = 0;
      foreach (got[i]) if (got[i] != 8'(i)) errs++;
      check("stream_words",   got.size(), 256);
      check("stream_errs",    errs,       0);
      check("stream_gaps",    gaps,       0);
      check("stream_max_cnt", max_cnt <= 2, 1);
      drain();

      // Fill to 4096, refuse one more, then drain in order.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 8'(i), 1'b0);
         tick();
      end
      check("fill_full",    full,    1);
      check("fill_s_ready", s_ready, 0);
      check("fill_count",   count,   4096);
      drive(1'b1, 8'hEE, 1'b0);
      #1;
      check("fill_no_wr_en", ram_wr_en_0, 0);
      tick();
      check("fill_count_after_extra", count, 4096);
      drive(1'b0, '0, 1'b1);
      idx = 0; errs = 0;
      if (m_valid) begin
         if (m_data != 8'(idx)) errs++;
         idx++;
      end
      tick();
      check("full_to_ready", s_ready, 1);
      for (int c = 0; c < 5000 && idx < DEPTH; c++) begin
         if (m_valid) begin
            if (m_data != 8'(idx)) errs++;
            idx++;
         end
         tick();
      end
      check("drain_words",   idx,     4096);
      check("drain_errs",    errs,    0);
      check("drain_empty_f", empty,   1);
      check("drain_m_valid", m_valid, 0);
      drive(1'b0, '0, 1'b0);

      // Wrap: move both pointers to address ~4090, fill to 4095, then
      // push and pop together so both cross address 4095 -> 0.
      stream_n = (4090 - (n_push % DEPTH) + DEPTH) % DEPTH;
      for (int i = 0; i < stream_n; i++) begin
         drive(1'b1, 8'($urandom), 1'b1);
         tick();
      end
      drain();
      for (int i = 0; i < DEPTH - 1; i++) begin
         drive(1'b1, 8'($urandom), 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b0);
      tick();
      check("wrap_count_start", count, 4095);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 8'($urandom), 1'b1);
         tick();
      end
      drive(1'b0, '0, 1'b0);
      check("wrap_count_end", count,   4095);
      check("wrap_m_valid",   m_valid, 1);
      drain();

      // Reset mid-stream discards everything; next word is read first.
      for (int i = 0; i < 37; i++) begin
         drive(1'b1, 8'($urandom), 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b0);
      tick();
      tick();
      check("mid_count",   count,   37);
      check("mid_m_valid", m_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_count",   count,   0);
      check("mid_rst_m_valid", m_valid, 0);
      check("mid_rst_empty",   empty,   1);
      check("mid_rst_s_ready", s_ready, 1);
      drive(1'b1, 8'h3C, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0);
      tick();
      check("mid_first_valid", m_valid, 1);
      check("mid_first_data",  m_data,  8'h3C);
      drain();

      // Push 100, pop 60, push 10: occupancy peaks at 100.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, 8'($urandom), 1'b0);
         tick();
      end
      for (int i = 0; i < 60; i++) begin
         drive(1'b0, '0, 1'b1);
         tick();
      end
      check("hwm_seq_count_mid", count, 40);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 8'($urandom), 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b0);
      check("hwm_seq_count_end", count, 50);
`ifdef DPR_FIFO_HWM_EN
      check("hwm_peak", hwm, 100);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
`ifdef DPR_FIFO_HWM_EN
      check("hwm_after_rst", hwm, 0);
`endif
      check("seq_rst_count", count, 0);

      // Randomized traffic in phases of varying push/pop pressure, with an
      // occasional reset. Upstream holds its word until it is accepted.
      for (int ph = 0; ph < 40; ph++) begin
         int pp, rp;
         pp = int'($urandom_range(95, 5));
         rp = int'($urandom_range(95, 5));
         for (int c = 0; c < 500; c++) begin
            if ($urandom_range(999) == 0) begin
               rst = 1'b1;
               drive(1'b0, '0, 1'b0);
               tick();
               rst = 1'b0;
            end else begin
               if (!(s_valid && !acc)) begin
                  s_valid = (int'($urandom_range(99)) < pp);
                  s_data  = 8'($urandom);
               end
               m_ready = (int'($urandom_range(99)) < rp);
               acc = s_valid && s_ready;
               tick();
            end
         end
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
